// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multicycle CPU control unit: FSM states,
// instruction opcodes and the ALU operand/operation select encodings.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXEC_R,
        S_EXEC_I,
        S_ALUWB,
        S_BRANCH,
        S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REGA  = 2'b10;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_SUB    = 2'b01;
    localparam logic [1:0] ALU_RFUNCT = 2'b10;
    localparam logic [1:0] ALU_IFUNCT = 2'b11;

endpackage

// File: rtl/wait_timer.sv
// Memory wait-state counter. Counts cycles spent waiting on mem_ready and
// flags the cycle on which one more wait would reach LIMIT.
module wait_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] count;

    // Wait count: clear wins over increment so each wait state starts at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + W'(1);
        end
    end

    // Expiry is combinational so the FSM can leave on the LIMIT-th wait cycle.
    assign expired = enable && (count == LAST);

endmodule

// File: rtl/multicycle_control.sv
// Control FSM for a multicycle RISC-V style datapath. Outputs are a Moore
// decode of state except the handshake-qualified write enables and the
// branch-condition pc_write.
module multicycle_control
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       oldpc_write,
    output logic       target_write,
    output logic       reg_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       iord,
    output logic       mem_to_reg,
    output logic       pc_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       instr_retired,
    output logic       illegal_instr,
    output logic       mem_timeout
);

    state_t state;
    state_t state_next;
    logic   waiting;
    logic   timer_clear;
    logic   timer_expired;
    logic   illegal_hit;
    logic   timeout_hit;
    logic   illegal_flag;
    logic   timeout_flag;

    // mem_ready only matters in the three states that wait on memory.
    assign waiting = ((state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR)) && !mem_ready;

    // Any state change restarts the count, so every wait state is entered at zero.
    assign timer_clear = (state_next != state);

    wait_timer #(
        .LIMIT(MEM_TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (timer_clear),
        .enable (waiting),
        .expired(timer_expired)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Sticky trap cause, recorded on the transition into TRAP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_flag <= 1'b0;
            timeout_flag <= 1'b0;
        end else begin
            if (illegal_hit) illegal_flag <= 1'b1;
            if (timeout_hit) timeout_flag <= 1'b1;
        end
    end

    assign illegal_instr = illegal_flag;
    assign mem_timeout   = timeout_flag;

    // Next-state and control decode; completion beats timeout in wait states.
    always_comb begin
        state_next    = state;
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        oldpc_write   = 1'b0;
        target_write  = 1'b0;
        reg_write     = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        iord          = 1'b0;
        mem_to_reg    = 1'b0;
        pc_src        = 1'b0;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_REGB;
        alu_op        = ALU_ADD;
        instr_retired = 1'b0;
        illegal_hit   = 1'b0;
        timeout_hit   = 1'b0;
        case (state)
            S_IDLE: state_next = S_FETCH;
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_a = SRCA_PC;
                alu_src_b = SRCB_FOUR;
                alu_op    = ALU_ADD;
                if (mem_ready) begin
                    ir_write    = 1'b1;
                    pc_write    = 1'b1;
                    oldpc_write = 1'b1;
                    state_next  = S_DECODE;
                end else if (timer_expired) begin
                    timeout_hit = 1'b1;
                    state_next  = S_TRAP;
                end
            end
            S_DECODE: begin
                alu_src_a    = SRCA_OLDPC;
                alu_src_b    = SRCB_IMM;
                target_write = 1'b1;
                case (opcode)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXEC_R;
                    OP_ITYPE:          state_next = S_EXEC_I;
                    OP_BRANCH:         state_next = S_BRANCH;
                    default: begin
                        illegal_hit = 1'b1;
                        state_next  = S_TRAP;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = SRCA_REGA;
                alu_src_b  = SRCB_IMM;
                state_next = (opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) begin
                    state_next = S_MEMWB;
                end else if (timer_expired) begin
                    timeout_hit = 1'b1;
                    state_next  = S_TRAP;
                end
            end
            S_MEMWB: begin
                reg_write     = 1'b1;
                mem_to_reg    = 1'b1;
                instr_retired = 1'b1;
                state_next    = S_FETCH;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) begin
                    instr_retired = 1'b1;
                    state_next    = S_FETCH;
                end else if (timer_expired) begin
                    timeout_hit = 1'b1;
                    state_next  = S_TRAP;
                end
            end
            S_EXEC_R: begin
                alu_src_a  = SRCA_REGA;
                alu_src_b  = SRCB_REGB;
                alu_op     = ALU_RFUNCT;
                state_next = S_ALUWB;
            end
            S_EXEC_I: begin
                alu_src_a  = SRCA_REGA;
                alu_src_b  = SRCB_IMM;
                alu_op     = ALU_IFUNCT;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write     = 1'b1;
                instr_retired = 1'b1;
                state_next    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = SRCA_REGA;
                alu_src_b = SRCB_REGB;
                alu_op    = ALU_SUB;
                pc_src    = 1'b1;
                case (funct3)
                    F3_BEQ: begin
                        pc_write      = zero;
                        instr_retired = 1'b1;
                        state_next    = S_FETCH;
                    end
                    F3_BNE: begin
                        pc_write      = !zero;
                        instr_retired = 1'b1;
                        state_next    = S_FETCH;
                    end
                    default: begin
                        illegal_hit = 1'b1;
                        state_next  = S_TRAP;
                    end
                endcase
            end
            S_TRAP: state_next = S_TRAP;
            default: state_next = S_IDLE;
        endcase
    end

endmodule
